// File: rtl/prog_loader_pkg.sv
// prog_loader shared types and constants.
// Checksum support is selected with PROG_LOADER_CHKSUM_EN.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_B2,
    ST_B1,
    ST_B0,
    ST_CHK
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int MAX_WORDS = 1024;
  localparam int ADDR_W    = 10;
  localparam int INSTR_W   = 18;
  localparam int CNT_W     = ADDR_W + 1;

  function automatic logic len_ok(input logic [CNT_W-1:0] n);
    return (n != '0) && (n <= CNT_W'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Inter-byte gap counter: reloads on each byte, counts down while
// enabled and flags expiry unless a byte lands in the expiry cycle.
module prog_loader_timeout #(
  parameter int unsigned CYCLES = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic reload_i,
  output logic expire_o
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !reload_i && (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: frames UART bytes into 18-bit words.
// Define PROG_LOADER_CHKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [7:0]         RX_DATA,
  input  logic               RX_VALID,
  output logic               PROG_WE,
  output logic [ADDR_W-1:0]  PROG_WADDR,
  output logic [INSTR_W-1:0] PROG_WDATA,
  output logic               MCU_HOLD,
  output logic               DONE,
  output logic               ERR
);

  state_e               state_q;
  logic [2:0]           len_hi_q;
  logic [CNT_W-1:0]     n_q;
  logic [CNT_W-1:0]     wcnt_q;
  logic [1:0]           b2_q;
  logic [7:0]           b1_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    waddr_q;
  logic [INSTR_W-1:0]   wdata_q;
  logic                 hold_q;
  logic                 done_q;
  logic                 err_q;
`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0]           chk_q;
`endif

  logic                 expire;
  logic [CNT_W-1:0]     len_w;
  logic [CNT_W-1:0]     wnext;

  assign len_w = {len_hi_q, RX_DATA};
  assign wnext = wcnt_q + CNT_W'(1);

  prog_loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (CLK),
    .rst_i    (RST),
    .en_i     (state_q != ST_IDLE),
    .reload_i (RX_VALID),
    .expire_o (expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      len_hi_q <= '0;
      n_q      <= '0;
      wcnt_q   <= '0;
      b2_q     <= '0;
      b1_q     <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (expire) begin
        err_q   <= 1'b1;
        hold_q  <= 1'b0;
        state_q <= ST_IDLE;
      end else if (RX_VALID) begin
        unique case (state_q)
          ST_IDLE: begin
            if (RX_DATA == SYNC_BYTE) begin
              err_q   <= 1'b0;
              hold_q  <= 1'b1;
              wcnt_q  <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
              chk_q   <= '0;
`endif
              state_q <= ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            len_hi_q <= RX_DATA[2:0];
            state_q  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            if (len_ok(len_w)) begin
              n_q     <= len_w;
              state_q <= ST_B2;
            end else begin
              err_q   <= 1'b1;
              hold_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          ST_B2: begin
            b2_q    <= RX_DATA[1:0];
`ifdef PROG_LOADER_CHKSUM_EN
            chk_q   <= chk_q ^ RX_DATA;
`endif
            state_q <= ST_B1;
          end
          ST_B1: begin
            b1_q    <= RX_DATA;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_q   <= chk_q ^ RX_DATA;
`endif
            state_q <= ST_B0;
          end
          ST_B0: begin
            we_q    <= 1'b1;
            waddr_q <= wcnt_q[ADDR_W-1:0];
            wdata_q <= {b2_q, b1_q, RX_DATA};
            wcnt_q  <= wnext;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_q   <= chk_q ^ RX_DATA;
            state_q <= (wnext == n_q) ? ST_CHK : ST_B2;
`else
            if (wnext == n_q) begin
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_B2;
            end
`endif
          end
`ifdef PROG_LOADER_CHKSUM_EN
          ST_CHK: begin
            if (RX_DATA == chk_q) begin
              done_q <= 1'b1;
            end else begin
              err_q  <= 1'b1;
            end
            hold_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign PROG_WE    = we_q;
  assign PROG_WADDR = waddr_q;
  assign PROG_WDATA = wdata_q;
  assign MCU_HOLD   = hold_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule
